// File: rtl/niosii_reset_sequencer.sv
// Merges watchdog, pushbutton and software requests into one fixed-length sys_reset pulse plus holdoff; sticky cause/count regs.
// Latency: wd/sw request -> sys_reset next cycle (ext +2 sync); readdata 1 cycle; no backpressure, slave always accepts.
module niosii_reset_sequencer #(
   parameter int PULSE_CYCLES   = 16,
   parameter int HOLDOFF_CYCLES = 8,
   parameter int CNT_W          = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wd_resetrequest,
   input  logic        ext_reset_req,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [15:0] writedata,
   output logic [15:0] readdata,
   output logic        sys_reset
);
   typedef enum logic [1:0] {IDLE, ASSERT, HOLDOFF} state_t;

   localparam logic [CNT_W-1:0] PULSE_INIT = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_INIT  = CNT_W'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);
   localparam logic [15:0]      PULSE_RO   = 16'(PULSE_CYCLES);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       cause;
   logic [7:0]       rst_count;
   logic             wd_prev, ext_s1, ext_s2, ext_s3;
   logic             wr, wd_rise, ext_rise, sw_req, any_req;
   logic [3:0]       cause_set;
   logic [15:0]      rd_mux;

   assign wr        = chipselect & ~write_n;
   assign wd_rise   = wd_resetrequest & ~wd_prev;
   assign ext_rise  = ext_s2 & ~ext_s3;
   assign sw_req    = wr && (address == 2'd1) && (writedata == 16'hA5A5);
   assign any_req   = wd_rise | ext_rise | sw_req;
   assign cause_set = {sw_req, ext_rise, wd_rise, 1'b0};

   // ext_s1/ext_s2 form the synchroniser; ext_s3 only serves edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wd_prev <= 1'b0;
         ext_s1  <= 1'b0;
         ext_s2  <= 1'b0;
         ext_s3  <= 1'b0;
      end else begin
         wd_prev <= wd_resetrequest;
         ext_s1  <= ext_reset_req;
         ext_s2  <= ext_s1;
         ext_s3  <= ext_s2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ASSERT;
         cnt       <= PULSE_INIT;
         sys_reset <= 1'b1;
         rst_count <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               if (any_req) begin
                  state     <= ASSERT;
                  cnt       <= PULSE_INIT;
                  sys_reset <= 1'b1;
               end
            end
            ASSERT: begin
               if (cnt == '0) begin
                  sys_reset <= 1'b0;
                  if (rst_count != 8'hFF) rst_count <= rst_count + 8'd1;
                  if (HOLDOFF_CYCLES == 0) begin
                     state <= IDLE;
                  end else begin
                     state <= HOLDOFF;
                     cnt   <= HOLD_INIT;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            HOLDOFF: begin
               if (cnt == '0) state <= IDLE;
               else           cnt   <= cnt - 1'b1;
            end
            default: begin
               state     <= IDLE;
               sys_reset <= 1'b0;
            end
         endcase
      end
   end

   // new request edges take priority over a simultaneous write-1-to-clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        cause <= 4'b0001;
      else if (wr && address == 2'd0)   cause <= (cause & ~writedata[3:0]) | cause_set;
      else                              cause <= cause | cause_set;
   end

   always_comb begin
      rd_mux = 16'd0;
      case (address)
         2'd0:    rd_mux = {7'd0, (state != IDLE), 4'd0, cause};
         2'd2:    rd_mux = {8'd0, rst_count};
         2'd3:    rd_mux = PULSE_RO;
         default: rd_mux = 16'd0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) readdata <= 16'd0;
      else       readdata <= rd_mux;
   end
endmodule

// File: tb/tb_niosii_reset_sequencer.sv
// Bench for niosii_reset_sequencer: table-driven software-write decode plus hand-written sequences.
`timescale 1ns/1ps
module tb_niosii_reset_sequencer;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        wd_resetrequest = 1'b0;
   logic        ext_reset_req = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [15:0] writedata = 16'd0;
   logic [15:0] readdata;
   logic        sys_reset;

   niosii_reset_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .wd_resetrequest (wd_resetrequest),
      .ext_reset_req   (ext_reset_req),
      .address         (address),
      .chipselect      (chipselect),
      .write_n         (write_n),
      .writedata       (writedata),
      .readdata        (readdata),
      .sys_reset       (sys_reset)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int hi_cnt = 0;
   int rises = 0;
   int rise_cyc = 0;
   logic prev_sr = 1'b0;
   logic rd_pend = 1'b0;
   logic [15:0] rd_q[$];
   string       rd_name[$];

   typedef struct {
      logic [1:0]  addr;
      logic [15:0] data;
      int          pulses;
      logic [15:0] cause;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      rd_pend <= chipselect & write_n;
   end

   // pulse bookkeeping and the read scoreboard, sampled mid-cycle
   always @(negedge clk) begin
      logic [15:0] e;
      string nm;
      if (!reset && sys_reset) hi_cnt++;
      if (sys_reset && !prev_sr) begin
         rises++;
         rise_cyc = cyc;
      end
      prev_sr = sys_reset;
      if (rd_pend) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_read: readdata 0x%0h with nothing expected", readdata);
         end else begin
            e  = rd_q.pop_front();
            nm = rd_name.pop_front();
            chk(nm, {16'd0, readdata}, {16'd0, e});
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [15:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      step(1);
      chipselect = 1'b0; write_n = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [15:0] e, input string nm);
      address = a; chipselect = 1'b1; write_n = 1'b1;
      rd_q.push_back(e);
      rd_name.push_back(nm);
      step(1);
      chipselect = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1, "timeout");
   end

   initial begin
      int h0, r0, trig, exp_cnt;

      vecs[0] = '{2'd1, 16'h1234, 0, 16'h0000};
      vecs[1] = '{2'd1, 16'hA5A4, 0, 16'h0000};
      vecs[2] = '{2'd2, 16'hA5A5, 0, 16'h0000};
      vecs[3] = '{2'd3, 16'hA5A5, 0, 16'h0000};
      vecs[4] = '{2'd1, 16'hA5A5, 1, 16'h0008};
      vecs[5] = '{2'd1, 16'h5A5A, 0, 16'h0000};

      // power-on reset
      step(3);
      chk("reset_sys_reset", {31'd0, sys_reset}, 32'd1);
      chk("reset_readdata", {16'd0, readdata}, 32'd0);
      reset = 1'b0;
      h0 = hi_cnt;
      step(30);
      chk("por_pulse_len", hi_cnt - h0, 16);
      chk("por_done_low", {31'd0, sys_reset}, 32'd0);
      exp_cnt = 1;
      rd(2'd0, 16'h0001, "por_cause");
      rd(2'd3, 16'd16, "pulse_cycles_ro");
      rd(2'd2, 16'(exp_cnt), "por_rst_count");

      // watchdog held two cycles
      wr(2'd0, 16'h000F);
      r0 = rises; h0 = hi_cnt; trig = cyc;
      wd_resetrequest = 1'b1;
      step(2);
      wd_resetrequest = 1'b0;
      rd(2'd2, 16'(exp_cnt), "wd_count_mid_pulse");
      rd(2'd0, 16'h0102, "wd_cause_busy");
      step(30);
      exp_cnt++;
      chk("wd_pulses", rises - r0, 1);
      chk("wd_latency", rise_cyc - trig, 1);
      chk("wd_pulse_len", hi_cnt - h0, 16);
      rd(2'd0, 16'h0002, "wd_cause");
      rd(2'd2, 16'(exp_cnt), "wd_rst_count");

      // pushbutton held 100 cycles
      wr(2'd0, 16'h000F);
      r0 = rises; h0 = hi_cnt; trig = cyc;
      ext_reset_req = 1'b1;
      step(100);
      ext_reset_req = 1'b0;
      step(30);
      exp_cnt++;
      chk("ext_pulses", rises - r0, 1);
      chk("ext_latency", rise_cyc - trig, 3);
      chk("ext_pulse_len", hi_cnt - h0, 16);
      rd(2'd0, 16'h0004, "ext_cause");
      rd(2'd2, 16'(exp_cnt), "ext_rst_count");

      // software write decode table
      for (int i = 0; i < 6; i++) begin
         wr(2'd0, 16'h000F);
         r0 = rises; h0 = hi_cnt; trig = cyc;
         wr(vecs[i].addr, vecs[i].data);
         step(30);
         exp_cnt += vecs[i].pulses;
         chk($sformatf("sw_vec%0d_pulses", i), rises - r0, vecs[i].pulses);
         chk($sformatf("sw_vec%0d_len", i), hi_cnt - h0, 16 * vecs[i].pulses);
         if (vecs[i].pulses != 0) chk($sformatf("sw_vec%0d_latency", i), rise_cyc - trig, 1);
         rd(2'd0, vecs[i].cause, $sformatf("sw_vec%0d_cause", i));
      end
      rd(2'd2, 16'(exp_cnt), "sw_rst_count");

      // watchdog edge inside holdoff
      wr(2'd0, 16'h000F);
      wd_resetrequest = 1'b1;
      step(1);
      wd_resetrequest = 1'b0;
      step(16);
      exp_cnt++;
      rd(2'd0, 16'h0102, "holdoff_busy");
      wr(2'd0, 16'h000F);
      r0 = rises; h0 = hi_cnt;
      wd_resetrequest = 1'b1;
      step(1);
      wd_resetrequest = 1'b0;
      step(30);
      chk("holdoff_no_pulse", rises - r0, 0);
      chk("holdoff_no_high", hi_cnt - h0, 0);
      rd(2'd0, 16'h0002, "holdoff_cause");

      // clear and set of the same bit in one cycle: set wins
      r0 = rises;
      address = 2'd0; writedata = 16'h000F; chipselect = 1'b1; write_n = 1'b0;
      wd_resetrequest = 1'b1;
      step(1);
      chipselect = 1'b0; write_n = 1'b1; wd_resetrequest = 1'b0;
      step(30);
      exp_cnt++;
      chk("set_wins_pulse", rises - r0, 1);
      rd(2'd0, 16'h0002, "set_wins_cause");

      // partial write-1-to-clear
      wr(2'd1, 16'hA5A5);
      step(30);
      exp_cnt++;
      rd(2'd0, 16'h000A, "two_causes");
      wr(2'd0, 16'h0002);
      rd(2'd0, 16'h0008, "partial_clear");

      // rst_count saturation
      for (int i = 0; i < 255; i++) begin
         wd_resetrequest = 1'b1;
         step(1);
         wd_resetrequest = 1'b0;
         step(25);
         if (exp_cnt < 255) exp_cnt++;
      end
      rd(2'd2, 16'(exp_cnt), "rst_count_saturate");

      // async reset in the middle of a pulse
      wr(2'd0, 16'h000F);
      wd_resetrequest = 1'b1;
      step(1);
      wd_resetrequest = 1'b0;
      step(5);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_sys_reset", {31'd0, sys_reset}, 32'd1);
      chk("async_rst_readdata", {16'd0, readdata}, 32'd0);
      step(2);
      reset = 1'b0;
      h0 = hi_cnt;
      rd(2'd2, 16'h0000, "restart_rst_count");
      rd(2'd0, 16'h0101, "restart_cause_busy");
      step(30);
      chk("restart_pulse_len", hi_cnt - h0, 16);
      rd(2'd0, 16'h0001, "restart_cause");
      rd(2'd2, 16'h0001, "restart_count_after");

      step(2);
      chk("rd_queue_empty", rd_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
